serial_tx_lane: RTL and testbench
=================================

Name: serial_tx_lane

Overview:
- Parallel-to-serial transmitter. It is the driving end of the single-bit serial lane that feeds the scalar/bus receiver-side benchmarks.
- Accepts one WIDTH-bit word through a valid/ready handshake.
- Emits a framed serial bit stream: start bit, data LSB-first, parity bit, then an idle gap.
- Sits in the SystemVerilog frontend benchmark set. It exercises sequential logic, a package-typed state enum and a bus-to-scalar sub-module connection.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- GAP_CYCLES, 2, idle cycles after the parity bit before the next word can be accepted; 0 is legal.
- PARITY_ODD, 0, 0 selects even parity (XOR of the data bits); 1 selects odd parity (inverted XOR).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to send.
- tx_bit  output  1  serial data.
- tx_en  output  1  high while tx_bit carries a frame bit.
- busy  output  1  high in any non-IDLE state.
- frame_done  output  1  one-cycle pulse after the parity bit.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - State = IDLE.
  - in_ready=1; tx_bit=0, tx_en=0, busy=0, frame_done=0.
  - Shift register and counters cleared.
- Reset asserted mid-frame aborts the frame. No frame_done is produced and no partial bits follow. After rst_n deasserts, the block is in IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_valid or in_data to any output.
- Handshake:
  - A word is accepted on a rising edge where in_valid && in_ready.
  - in_ready is high only in IDLE.
  - in_data is captured into the shift register at acceptance. Later changes to in_data are ignored.
  - in_valid while not ready has no effect.
- States: IDLE, START, DATA, PARITY, GAP.
  - IDLE -> START on acceptance.
  - START: lasts 1 cycle; tx_en=1, tx_bit=1.
  - START -> DATA.
  - DATA: lasts WIDTH cycles; tx_en=1; tx_bit = data bit 0 first, then bit 1, up to bit WIDTH-1.
  - DATA uses a bit counter of width $clog2(WIDTH). It advances to PARITY when the counter reaches WIDTH-1.
  - PARITY: lasts 1 cycle; tx_en=1; tx_bit = ^data XOR PARITY_ODD.
  - PARITY -> GAP when GAP_CYCLES>0; otherwise PARITY -> IDLE.
  - GAP: lasts GAP_CYCLES cycles; tx_en=0, tx_bit=0. GAP -> IDLE when the gap counter reaches GAP_CYCLES-1.
- Parity is accumulated while the bits shift out, not recomputed from in_data.
- Timing, with acceptance at edge T:
  - START is visible in cycle T+1.
  - Data bits in cycles T+2..T+WIDTH+1.
  - Parity in cycle T+WIDTH+2.
  - frame_done=1 only in cycle T+WIDTH+3, independent of GAP_CYCLES.
  - in_ready returns at T+WIDTH+3+GAP_CYCLES.
- Minimum frame-to-frame spacing is WIDTH+3+GAP_CYCLES cycles. There is no overlap and no skid buffer.
- In every state other than START, DATA and PARITY: tx_en=0 and tx_bit=0.

Decomposition:
- Package serial_lane_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, GAP};
  - localparam logic START_BIT = 1'b1;
  - localparam logic IDLE_BIT = 1'b0.
- One sub-module, tx_shift_reg:
  - Parameter WIDTH.
  - Inputs: clk, rst_n, load, shift, d[WIDTH-1:0].
  - Outputs: q_lsb (1 bit) and par (1 bit).
  - Loads d on load. Shifts right on shift, filling with 0. Accumulates running XOR of shifted-out bits into par; par clears on load.
  - Its bus input is driven from in_data; its scalar q_lsb output drives the tx_bit mux.

Test Plan:
- Reset then idle, rst_n released, in_valid=0 for 5 cycles -> in_ready=1, busy=0, tx_en=0, tx_bit=0, frame_done=0 throughout.
- Single frame, WIDTH=8, GAP_CYCLES=2, PARITY_ODD=0, in_data=8'hA5 accepted at T:
  - tx_en=1 for cycles T+1..T+10.
  - tx_bit sequence 1, 1,0,1,0,0,1,0,1, 0.
  - frame_done only at T+11; in_ready=1 again at T+13.
- Parity and odd mode, in_data=8'h07 -> parity bit 1; same word with PARITY_ODD=1 -> parity bit 0.
- Data stability and back-pressure:
  - in_data changed to 8'hFF at T+3 -> stream still carries 8'hA5.
  - in_valid held high continuously -> second acceptance exactly at T+13, START at T+14.
- GAP_CYCLES=0, in_data=8'h3C at T -> parity at T+10; frame_done and in_ready both at T+11; next START at T+12 if in_valid is held.
- Reset mid-frame, rst_n pulsed low during cycle T+5 -> outputs go to reset values asynchronously, with no frame_done. A new word accepted after release produces a complete, correct frame.

Source files
------------

// File: rtl/serial_tx_lane_pkg.sv
// ----------------------------------------------------------------------------
// serial_lane_pkg
// Shared types and constants for the serial transmit lane.
//   tx_state_t : frame sequencer states (IDLE, START, DATA, PARITY, GAP)
//   START_BIT  : line level driven during the start bit
//   IDLE_BIT   : line level driven whenever no frame bit is on the wire
// ----------------------------------------------------------------------------
package serial_lane_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        GAP
    } tx_state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic IDLE_BIT  = 1'b0;

endpackage

// File: rtl/serial_tx_lane_if.sv
// ----------------------------------------------------------------------------
// serial_tx_lane_if
// Valid/ready word handshake feeding the serial transmitter.
//   in_valid : producer offers a word
//   in_ready : transmitter can accept a word this cycle
//   in_data  : WIDTH-bit word to send
// Modports:
//   master : word producer (drives in_valid/in_data)
//   slave  : transmitter   (drives in_ready)
// ----------------------------------------------------------------------------
interface serial_tx_lane_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/serial_tx_lane_shift.sv
// ----------------------------------------------------------------------------
// tx_shift_reg
// Right-shifting parallel-load register with a running parity of the bits
// that have left through the LSB.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture d, clear parity
//   shift      : shift right (zero fill), fold outgoing LSB into parity
//   d          : parallel word
//   q_lsb      : current LSB (next bit to leave)
//   par        : XOR of every bit shifted out since the last load
// ----------------------------------------------------------------------------
module tx_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_lsb,
    output logic             par
);

    logic [WIDTH-1:0] data_q;
    logic             par_q;

    // Load wins over shift; parity is built up from the bits actually sent
    // rather than recomputed from the captured word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else if (load) begin
            data_q <= d;
            par_q  <= 1'b0;
        end else if (shift) begin
            data_q <= {1'b0, data_q[WIDTH-1:1]};
            par_q  <= par_q ^ data_q[0];
        end
    end

    assign q_lsb = data_q[0];
    assign par   = par_q;

endmodule

// File: rtl/serial_tx_lane.sv
// ----------------------------------------------------------------------------
// serial_tx_lane
// Parallel-to-serial transmitter. Accepts one word over a valid/ready
// handshake and sends: start bit, data LSB-first, parity bit, idle gap.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : word handshake (slave side: in_valid, in_ready, in_data)
//   tx_bit      : serial data
//   tx_en       : high while tx_bit carries a frame bit
//   busy        : high whenever the sequencer is not idle
//   frame_done  : one-cycle pulse in the cycle after the parity bit
// All outputs come straight from flops, so nothing on the handshake inputs
// reaches an output combinationally.
// ----------------------------------------------------------------------------
module serial_tx_lane
    import serial_lane_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int PARITY_ODD = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_tx_lane_if.slave        bus,
    output logic                   tx_bit,
    output logic                   tx_en,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic          PAR_FLIP = (PARITY_ODD != 0);

    tx_state_t      state_q;
    logic [BW-1:0]  bit_cnt_q;
    logic [GW-1:0]  gap_cnt_q;
    logic           in_ready_q;
    logic           tx_bit_q;
    logic           tx_en_q;
    logic           busy_q;
    logic           frame_done_q;

    logic           load;
    logic           shift;
    logic           q_lsb;
    logic           par;

    // in_ready_q is only ever high in IDLE, so it alone qualifies acceptance.
    assign load  = bus.in_valid && in_ready_q;

    // The bit registered onto the line at each edge is shifted out at that
    // same edge: once leaving START (bit 0) and for every DATA cycle except
    // the last, which instead registers the finished parity.
    assign shift = (state_q == START) ||
                   ((state_q == DATA) && (bit_cnt_q != BIT_LAST));

    tx_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .d     (bus.in_data),
        .q_lsb (q_lsb),
        .par   (par)
    );

    // Frame sequencer. Outputs are registered alongside the state so that
    // each output reflects the state entered at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            in_ready_q   <= 1'b1;
            tx_bit_q     <= IDLE_BIT;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q    <= START;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_en_q    <= 1'b1;
                        tx_bit_q   <= START_BIT;
                    end
                end
                START: begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                    tx_bit_q  <= q_lsb;
                end
                DATA: begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_q  <= PARITY;
                        tx_bit_q <= par ^ PAR_FLIP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        tx_bit_q  <= q_lsb;
                    end
                end
                PARITY: begin
                    tx_en_q      <= 1'b0;
                    tx_bit_q     <= IDLE_BIT;
                    frame_done_q <= 1'b1;
                    gap_cnt_q    <= '0;
                    if (GAP_CYCLES > 0) begin
                        state_q <= GAP;
                    end else begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    tx_en_q    <= 1'b0;
                    tx_bit_q   <= IDLE_BIT;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign tx_bit       = tx_bit_q;
    assign tx_en        = tx_en_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_serial_tx_lane.sv
// ----------------------------------------------------------------------------
// tb_serial_tx_lane
// Directed bench for serial_tx_lane. Three instances cover even parity with a
// 2-cycle gap, odd parity, and a zero-length gap.
// ----------------------------------------------------------------------------
module tb_serial_tx_lane;

    logic       clk;
    logic       rst_n;
    logic [2:0] inValid;
    logic [7:0] inData [3];

    wire  [2:0] rdy;
    wire  [2:0] txBit;
    wire  [2:0] txEn;
    wire  [2:0] busyW;
    wire  [2:0] doneW;

    int checks;
    int errors;

    serial_tx_lane_if #(.WIDTH(8)) ifc0 ();
    serial_tx_lane_if #(.WIDTH(8)) ifc1 ();
    serial_tx_lane_if #(.WIDTH(8)) ifc2 ();

    assign ifc0.in_valid = inValid[0];
    assign ifc1.in_valid = inValid[1];
    assign ifc2.in_valid = inValid[2];
    assign ifc0.in_data  = inData[0];
    assign ifc1.in_data  = inData[1];
    assign ifc2.in_data  = inData[2];
    assign rdy[0]        = ifc0.in_ready;
    assign rdy[1]        = ifc1.in_ready;
    assign rdy[2]        = ifc2.in_ready;

    serial_tx_lane #(.WIDTH(8), .GAP_CYCLES(2), .PARITY_ODD(0)) dutEven (
        .clk(clk), .rst_n(rst_n), .bus(ifc0),
        .tx_bit(txBit[0]), .tx_en(txEn[0]), .busy(busyW[0]), .frame_done(doneW[0])
    );

    serial_tx_lane #(.WIDTH(8), .GAP_CYCLES(2), .PARITY_ODD(1)) dutOdd (
        .clk(clk), .rst_n(rst_n), .bus(ifc1),
        .tx_bit(txBit[1]), .tx_en(txEn[1]), .busy(busyW[1]), .frame_done(doneW[1])
    );

    serial_tx_lane #(.WIDTH(8), .GAP_CYCLES(0), .PARITY_ODD(0)) dutNoGap (
        .clk(clk), .rst_n(rst_n), .bus(ifc2),
        .tx_bit(txBit[2]), .tx_en(txEn[2]), .busy(busyW[2]), .frame_done(doneW[2])
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Packs {in_ready, busy, tx_en, tx_bit, frame_done} of one instance.
    function automatic logic [4:0] outVec(input int d);
        return {rdy[d], busyW[d], txEn[d], txBit[d], doneW[d]};
    endfunction

    // Offers a word to instance d and walks the whole frame cycle by cycle,
    // comparing against the hand-derived expected line. Entered and left on
    // a falling edge. waitCycles reports how many cycles the offer waited
    // for in_ready before the accepting edge.
    task automatic applyStimulus(input int d, input logic [7:0] data, input int gap,
                                 input logic expPar, input bit holdValid,
                                 input bit corruptData, input string name,
                                 output int waitCycles);
        waitCycles   = 0;
        inData[d]    = data;
        inValid[d]   = 1'b1;
        while (rdy[d] !== 1'b1 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (rdy[d] !== 1'b1) begin
            checkOutput({name, "_ready_timeout"}, 32'(rdy[d]), 32'd1);
            inValid[d] = 1'b0;
            return;
        end
        // Cycle T+1: start bit on the line, handshake closed.
        @(negedge clk);
        if (!holdValid) inValid[d] = 1'b0;
        checkOutput({name, "_start"}, 32'(outVec(d)), 32'b01110);
        // Cycles T+2..T+9: data LSB first.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (corruptData && i == 1) inData[d] = 8'hFF;
            checkOutput($sformatf("%s_bit%0d", name, i), 32'(outVec(d)),
                        32'({3'b011, data[i], 1'b0}));
        end
        // Cycle T+10: parity.
        @(negedge clk);
        checkOutput({name, "_parity"}, 32'(outVec(d)), 32'({3'b011, expPar, 1'b0}));
        // Cycle T+11: frame_done pulse; ready already back when there is no gap.
        @(negedge clk);
        checkOutput({name, "_done"}, 32'(outVec(d)),
                    (gap == 0) ? 32'b10001 : 32'b01001);
        // Gap cycles: line idle, ready returns in the last one.
        for (int g = 1; g <= gap; g++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_gap%0d", name, g), 32'(outVec(d)),
                        (g == gap) ? 32'b10000 : 32'b01000);
        end
    endtask

    initial begin
        int w;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        inValid = 3'b000;
        for (int k = 0; k < 3; k++) inData[k] = 8'h00;

        // Reset held, then five idle cycles.
        repeat (2) @(negedge clk);
        checkOutput("rst_hold", 32'(outVec(0)), 32'b10000);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("idle%0d", c), 32'(outVec(0)), 32'b10000);
        end
        checkOutput("idle_odd", 32'(outVec(1)), 32'b10000);
        checkOutput("idle_nogap", 32'(outVec(2)), 32'b10000);

        // A5 with in_data disturbed at T+3: line must still carry A5.
        applyStimulus(0, 8'hA5, 2, 1'b0, 1'b0, 1'b1, "a5", w);

        // Back-to-back with in_valid held: second word accepted at T+13.
        @(negedge clk);
        applyStimulus(0, 8'hA5, 2, 1'b0, 1'b1, 1'b0, "hold1", w);
        applyStimulus(0, 8'h0B, 2, 1'b1, 1'b0, 1'b0, "hold2", w);
        checkOutput("b2b_wait", 32'(w), 32'd0);

        // Parity modes on the same word.
        @(negedge clk);
        applyStimulus(0, 8'h07, 2, 1'b1, 1'b0, 1'b0, "even07", w);
        applyStimulus(1, 8'h07, 2, 1'b0, 1'b0, 1'b0, "odd07", w);

        // Zero gap: done and ready together, next start right after.
        applyStimulus(2, 8'h3C, 0, 1'b0, 1'b1, 1'b0, "nogap1", w);
        applyStimulus(2, 8'hFF, 0, 1'b0, 1'b0, 1'b0, "nogap2", w);
        checkOutput("nogap_wait", 32'(w), 32'd0);

        // Reset in the middle of a frame (cycle T+5).
        @(negedge clk);
        inData[0]  = 8'hA5;
        inValid[0] = 1'b1;
        @(negedge clk);
        inValid[0] = 1'b0;
        checkOutput("mid_started", 32'(outVec(0)), 32'b01110);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_async", 32'(outVec(0)), 32'b10000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_hold%0d", c), 32'(outVec(0)), 32'b10000);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_after%0d", c), 32'(outVec(0)), 32'b10000);
        end
        applyStimulus(0, 8'h0B, 2, 1'b1, 1'b0, 1'b0, "post_rst", w);
        checkOutput("post_rst_wait", 32'(w), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
